// File: rtl/regalu_pipe.sv
// Register file plus ALU as a 3-stage pipeline: operand read, execute, writeback.
// Operands come from full forwarding, so dependent instructions never stall.
module regalu_pipe #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [AW-1:0]    Aselect,
    input  logic [AW-1:0]    Bselect,
    input  logic [AW-1:0]    Dselect,
    input  logic [2:0]       S,
    input  logic             Cin,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus,
    output logic [WIDTH-1:0] dbus,
    output logic             dvalid,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [2:0] {
        OP_XOR  = 3'b000,
        OP_XNOR = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_OR   = 3'b100,
        OP_NOR  = 3'b101,
        OP_AND  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    op_e              op_q, op_d;
    logic             cin_q, cin_d;
    logic [AW-1:0]    dsel2_q, dsel2_d;
    logic             valid2_q, valid2_d;

    logic [WIDTH-1:0] dbus_q, dbus_d;
    logic [AW-1:0]    dsel3_q, dsel3_d;
    logic             dvalid_q, dvalid_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic [WIDTH-1:0] fwd_a, fwd_b;

    always_comb begin
        b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
        sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_q};
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op_q)
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_OR:   alu_res = a_q | b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_AND:  alu_res = a_q & b_q;
            OP_PASS: alu_res = a_q;
        endcase
    end

    // Youngest producer wins: the instruction in execute beats the one in writeback.
    always_comb begin
        fwd_a = '0;
        if (Aselect == '0)
            fwd_a = '0;
        else if (valid2_q && dsel2_q == Aselect)
            fwd_a = alu_res;
        else if (dvalid_q && dsel3_q == Aselect)
            fwd_a = dbus_q;
        else
            fwd_a = regs_q[Aselect];

        fwd_b = '0;
        if (Bselect == '0)
            fwd_b = '0;
        else if (valid2_q && dsel2_q == Bselect)
            fwd_b = alu_res;
        else if (dvalid_q && dsel3_q == Bselect)
            fwd_b = dbus_q;
        else
            fwd_b = regs_q[Bselect];
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cin_d    = cin_q;
        dsel2_d  = dsel2_q;
        valid2_d = in_valid;
        if (in_valid) begin
            a_d     = fwd_a;
            b_d     = fwd_b;
            op_d    = op_e'(S);
            cin_d   = Cin;
            dsel2_d = Dselect;
        end

        dbus_d   = dbus_q;
        dsel3_d  = dsel3_q;
        dvalid_d = valid2_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (valid2_q) begin
            dbus_d  = alu_res;
            dsel3_d = dsel2_q;
            cout_d  = alu_cout;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
        end

        regs_d = regs_q;
        if (dvalid_q && dsel3_q != '0)
            regs_d[dsel3_q] = dbus_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_XOR;
            cin_q    <= 1'b0;
            dsel2_q  <= '0;
            valid2_q <= 1'b0;
            dbus_q   <= '0;
            dsel3_q  <= '0;
            dvalid_q <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            dsel2_q  <= dsel2_d;
            valid2_q <= valid2_d;
            dbus_q   <= dbus_d;
            dsel3_q  <= dsel3_d;
            dvalid_q <= dvalid_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            regs_q   <= regs_d;
        end
    end

    assign abus   = a_q;
    assign bbus   = b_q;
    assign dbus   = dbus_q;
    assign dvalid = dvalid_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule
